sdram_bus_bridge: RTL

Sits between the 32-bit CPU/system bus and the 16-bit SDRAM controller host port. Splits each 32-bit bus access into one or two 16-bit controller accesses, sequences the controller's complete-pulse handshake and assembles 32-bit read data. Returns a single-cycle acknowledge to the bus master.

---
 rtl/sdram_bus_bridge_if.sv | 32 +++
 rtl/sdram_bus_bridge.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sdram_bus_bridge_if.sv
// Bus-side and SDRAM-controller-host-side signals of the 32-to-16-bit bridge.
// The slave modport is the bridge; the master modport is its surroundings (CPU bus plus controller).
interface sdram_bus_bridge_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_bytesel;
  logic        bus_wr_en;
  logic        bus_access;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] h_addr;
  logic [15:0] h_wdata;
  logic        h_wr_en;
  logic [1:0]  h_bytesel;
  logic [15:0] h_rdata;
  logic        h_compl;
  logic        h_config_done;

  modport slave (
    input  bus_addr, bus_wdata, bus_bytesel, bus_wr_en, bus_access,
    output bus_ack, bus_rdata,
    output h_addr, h_wdata, h_wr_en, h_bytesel,
    input  h_rdata, h_compl, h_config_done
  );

  modport master (
    output bus_addr, bus_wdata, bus_bytesel, bus_wr_en, bus_access,
    input  bus_ack, bus_rdata,
    input  h_addr, h_wdata, h_wr_en, h_bytesel,
    output h_rdata, h_compl, h_config_done
  );
endinterface

// File: rtl/sdram_bus_bridge.sv
// Splits 32-bit bus accesses into one or two 16-bit SDRAM controller accesses
// and assembles read data; all outputs are registered.
//
// state  | meaning
// SETTLE | post-reset wait, controller completions ignored
// IDLE   | waiting for a request with the SDRAM initialised
// LOW    | lower half-word access in flight
// HIGH   | upper half-word access in flight
// ACK    | bus_ack pulse being issued
module sdram_bus_bridge #(
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input logic              clk,
  input logic              rst,
  sdram_bus_bridge_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {S_SETTLE, S_IDLE, S_LOW, S_HIGH, S_ACK} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [29:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       bytesel_q, bytesel_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             bus_ack_q, bus_ack_d;
  logic [31:0]      bus_rdata_q, bus_rdata_d;
  logic [31:0]      h_addr_q, h_addr_d;
  logic [15:0]      h_wdata_q, h_wdata_d;
  logic             h_wr_en_q, h_wr_en_d;
  logic [1:0]       h_bytesel_q, h_bytesel_d;

  function automatic logic [15:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    bytesel_d    = bytesel_q;
    wr_en_d      = wr_en_q;
    rdata_d      = rdata_q;
    bus_ack_d    = 1'b0;
    bus_rdata_d  = 32'h0;
    h_addr_d     = h_addr_q;
    h_wdata_d    = h_wdata_q;
    h_wr_en_d    = 1'b0;
    h_bytesel_d  = 2'b00;

    case (state_q)
      S_SETTLE: begin
        if (settle_cnt_q == CNT_LAST) begin
          state_d      = S_IDLE;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end

      S_IDLE: begin
        if (bus.bus_access && bus.h_config_done) begin
          addr_d    = bus.bus_addr[31:2];
          wdata_d   = bus.bus_wdata;
          bytesel_d = bus.bus_bytesel;
          wr_en_d   = bus.bus_wr_en;
          rdata_d   = 32'h0;
          if (bus.bus_bytesel[1:0] != 2'b00) begin
            state_d     = S_LOW;
            h_addr_d    = {bus.bus_addr[31:2], 2'b00};
            h_wdata_d   = bus.bus_wdata[15:0];
            h_bytesel_d = bus.bus_bytesel[1:0];
            h_wr_en_d   = bus.bus_wr_en;
          end else if (bus.bus_bytesel[3:2] != 2'b00) begin
            state_d     = S_HIGH;
            h_addr_d    = {bus.bus_addr[31:2], 2'b10};
            h_wdata_d   = bus.bus_wdata[31:16];
            h_bytesel_d = bus.bus_bytesel[3:2];
            h_wr_en_d   = bus.bus_wr_en;
          end else begin
            state_d = S_ACK;
          end
        end
      end

      S_LOW: begin
        h_bytesel_d = h_bytesel_q;
        h_wr_en_d   = h_wr_en_q;
        if (bus.h_compl) begin
          if (!wr_en_q)
            rdata_d[15:0] = bus.h_rdata & lane_mask(bytesel_q[1:0]);
          if (bytesel_q[3:2] != 2'b00) begin
            state_d     = S_HIGH;
            h_addr_d    = {addr_q, 2'b10};
            h_wdata_d   = wdata_q[31:16];
            h_bytesel_d = bytesel_q[3:2];
            h_wr_en_d   = wr_en_q;
          end else begin
            state_d     = S_ACK;
            h_bytesel_d = 2'b00;
            h_wr_en_d   = 1'b0;
            bus_ack_d   = 1'b1;
            bus_rdata_d = rdata_d;
          end
        end
      end

      S_HIGH: begin
        h_bytesel_d = h_bytesel_q;
        h_wr_en_d   = h_wr_en_q;
        if (bus.h_compl) begin
          if (!wr_en_q)
            rdata_d[31:16] = bus.h_rdata & lane_mask(bytesel_q[3:2]);
          state_d     = S_ACK;
          h_bytesel_d = 2'b00;
          h_wr_en_d   = 1'b0;
          bus_ack_d   = 1'b1;
          bus_rdata_d = rdata_d;
        end
      end

      S_ACK: begin
        // ack already raised on the completion edge; a zero-bytesel request raises it here
        if (bus_ack_q) begin
          state_d = S_IDLE;
        end else begin
          bus_ack_d   = 1'b1;
          bus_rdata_d = rdata_q;
        end
      end

      default: state_d = S_SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_SETTLE;
      settle_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      bytesel_q    <= '0;
      wr_en_q      <= 1'b0;
      rdata_q      <= '0;
      bus_ack_q    <= 1'b0;
      bus_rdata_q  <= '0;
      h_addr_q     <= '0;
      h_wdata_q    <= '0;
      h_wr_en_q    <= 1'b0;
      h_bytesel_q  <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      bytesel_q    <= bytesel_d;
      wr_en_q      <= wr_en_d;
      rdata_q      <= rdata_d;
      bus_ack_q    <= bus_ack_d;
      bus_rdata_q  <= bus_rdata_d;
      h_addr_q     <= h_addr_d;
      h_wdata_q    <= h_wdata_d;
      h_wr_en_q    <= h_wr_en_d;
      h_bytesel_q  <= h_bytesel_d;
    end
  end

  assign bus.bus_ack   = bus_ack_q;
  assign bus.bus_rdata = bus_rdata_q;
  assign bus.h_addr    = h_addr_q;
  assign bus.h_wdata   = h_wdata_q;
  assign bus.h_wr_en   = h_wr_en_q;
  assign bus.h_bytesel = h_bytesel_q;
endmodule
